alu_seq: RTL
============

Name: alu_seq

Overview:
- Registered, parametrised successor to the datapath ALU, sitting in the execute stage.
- Full RV32I ALU operation set completes in one cycle.
- RV32M multiply/divide/remainder runs on an iterative shift-add / restoring-divide engine.
- start/busy/done handshake lets the core stall while a multi-cycle operation runs.

Parameters:
- XLEN, 32, operand and result width; must be a power of two, at least 8.
- OPW, 5, width of the operation code.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only while busy=0.
- in_0  input  XLEN  operand A (rs1); sampled when start is accepted.
- in_1  input  XLEN  operand B (rs2/imm); sampled when start is accepted.
- operation  input  OPW  operation code; sampled when start is accepted.
- busy  output  1  a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse; out and zero are valid and newly updated.
- out  output  XLEN  registered result; holds its value until the next done.
- zero  output  1  registered; equals (out == 0), updated together with out.

Behaviour:
- Reset (rst=1 at an edge): out=0, zero=1, busy=0, done=0, engine cleared, FSM to IDLE.
  - Reset aborts any in-flight operation; no done is issued for it.
- Operation codes:
  - AND=00000, OR=00001, ADD=00010, XOR=00011, SLL=00100, SRL=00101, SUB=00110, SRA=00111, SLT=01000, SLTU=01001.
  - MUL=10000, MULH=10001, MULHSU=10010, MULHU=10011, DIV=10100, DIVU=10101, REM=10110, REMU=10111.
  - Any other code is single-cycle with result 0.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE, start=0: done=0, nothing changes.
- IDLE, start=1, single-cycle operation:
  - Result registered at that edge; done=1 in the following cycle (latency 1); stays in IDLE.
  - Shifts use in_1[log2(XLEN)-1:0] only.
  - SLT/SLTU produce 0 or 1, zero-extended.
  - ADD/SUB wrap modulo 2^XLEN.
- IDLE, start=1, multiply:
  - Latch operand magnitudes and result sign; busy=1; go to MUL.
  - MUL runs exactly XLEN iterations (one per cycle) into a 2*XLEN accumulator, then goes to FIN.
  - In FIN: sign fix-up, select low half (MUL) or high half (MULH*), register out/zero, busy=0.
  - done=1 in the next cycle. Total start-to-done latency = XLEN+2 cycles.
- IDLE, start=1, divide/remainder:
  - Same flow through DIV, XLEN restoring iterations, then FIN. Latency XLEN+2.
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A).
- Divide fast paths (no DIV state, latency 1, like single-cycle operations):
  - B=0: DIV/DIVU give all-ones; REM/REMU give A.
  - Signed overflow (A = most negative, B = -1): DIV gives A; REM gives 0.
- start while busy=1 is ignored, and so are operand changes. done is never asserted in the same cycle as busy=1.
- Back-to-back: start may be asserted in the same cycle as done. It is accepted because busy=0.
- MULHSU: in_0 signed, in_1 unsigned.

Decomposition:
- Shared header/package (ALU_codes.h, extended):
  - All OPW-wide operation-code constants.
  - FSM state encodings.
  - Helper constant for log2(XLEN).
- One sub-module, serial_muldiv:
  - Holds the accumulator/remainder and counter registers and the per-iteration shift-add/subtract.
  - Interface: load, mode (mul/div), iterate, cnt_done.
- alu_seq keeps the FSM, the single-cycle datapath, sign handling, fast paths and the output registers.

Test Plan:
- Reset mid-operation: start MUL 7*6, assert rst at cycle 5 -> busy=0, done never pulses, out=0, zero=1.
- Single-cycle:
  - SUB 5-5 -> done next cycle, out=0, zero=1.
  - SRA 0x80000000 by 0x24 (shift amount 4) -> out=0xF8000000.
  - SLTU 1 vs 0xFFFFFFFF -> out=1.
- Multiply:
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> out=1 after 34 cycles.
  - MULH same operands -> out=0.
  - MULHU same operands -> out=0xFFFFFFFE.
- Divide:
  - DIV -7/2 -> out=0xFFFFFFFD (-3), latency 34.
  - REM -7/2 -> out=0xFFFFFFFF (-1).
  - DIVU 100/7 -> out=14.
- Fast paths:
  - DIV 9/0 -> 0xFFFFFFFF, latency 1.
  - REMU 9/0 -> 9.
  - DIV 0x80000000/-1 -> 0x80000000.
  - REM 0x80000000/-1 -> 0.
- Handshake: during a DIV, pulse start with ADD 1+1 -> ignored; the DIV result arrives. Then start ADD in the done cycle -> out=2 exactly one cycle later.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared operation codes, FSM state encoding and width helpers
// for the sequential ALU and its iterative multiply/divide engine.
package alu_seq_pkg;

  // Operation codes are 5 bits wide.
  // A wider OPW only adds upper bits, which must be zero for a valid code.
  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_AND    = 5'b00000;
  localparam logic [OPC_W-1:0] OP_OR     = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ADD    = 5'b00010;
  localparam logic [OPC_W-1:0] OP_XOR    = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SLL    = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SRL    = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB    = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SRA    = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SLT    = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SLTU   = 5'b01001;
  localparam logic [OPC_W-1:0] OP_MUL    = 5'b10000;
  localparam logic [OPC_W-1:0] OP_MULH   = 5'b10001;
  localparam logic [OPC_W-1:0] OP_MULHSU = 5'b10010;
  localparam logic [OPC_W-1:0] OP_MULHU  = 5'b10011;
  localparam logic [OPC_W-1:0] OP_DIV    = 5'b10100;
  localparam logic [OPC_W-1:0] OP_DIVU   = 5'b10101;
  localparam logic [OPC_W-1:0] OP_REM    = 5'b10110;
  localparam logic [OPC_W-1:0] OP_REMU   = 5'b10111;

  // Default datapath width and its shift-amount width.
  localparam int XLEN_DEF      = 32;
  localparam int LOG2_XLEN_DEF = $clog2(XLEN_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle of the sequential ALU.
//   master: start, in_0, in_1, operation out; busy, done, out, zero in
//   slave : the reverse (the ALU side)
interface alu_seq_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
);
  logic            start;
  logic [XLEN-1:0] in_0;
  logic [XLEN-1:0] in_1;
  logic [OPW-1:0]  operation;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] out;
  logic            zero;

  modport master (output start, in_0, in_1, operation,
                  input  busy, done, out, zero);
  modport slave  (input  start, in_0, in_1, operation,
                  output busy, done, out, zero);
endinterface

// File: rtl/alu_seq_serial_muldiv.sv
// serial_muldiv: one-bit-per-cycle unsigned multiply (shift-add) and
// restoring divide on operand magnitudes.
//   load     : capture a_mag / b_mag / mode, clear the counter
//   mode     : 0 = multiply, 1 = divide
//   iterate  : perform one step
//   cnt_done : the step being performed now is the last one (step XLEN)
//   acc      : multiply -> 2*XLEN product
//              divide   -> {remainder, quotient}
module serial_muldiv
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mode,
  input  logic              iterate,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic              cnt_done,
  output logic [2*XLEN-1:0] acc
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] opb;
  logic [CW-1:0]   cnt;
  logic            mode_q;
  logic [XLEN-1:0] hi, lo;
  logic [XLEN:0]   sum, diff;

  assign hi = acc[2*XLEN-1:XLEN];
  assign lo = acc[XLEN-1:0];

  // Multiply: conditionally add the multiplicand into the high half.
  // The carry is kept and shifted back in.
  assign sum  = {1'b0, hi} + {1'b0, (lo[0] ? opb : {XLEN{1'b0}})};
  // Divide: trial-subtract from the partial remainder shifted left by one.
  // A set top bit means borrow, so the remainder is restored.
  assign diff = {hi, lo[XLEN-1]} - {1'b0, opb};

  assign cnt_done = (cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      acc    <= {{XLEN{1'b0}}, a_mag};
      opb    <= b_mag;
      cnt    <= '0;
      mode_q <= mode;
    end else if (iterate) begin
      cnt <= cnt + 1'b1;
      if (!mode_q)
        acc <= {sum, lo[XLEN-1:1]};
      else if (!diff[XLEN])
        acc <= {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
      else
        acc <= {hi[XLEN-2:0], lo[XLEN-1], lo[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered RV32I/RV32M execute-stage ALU.
// Single-cycle operations and divide fast paths finish with latency 1.
// Multiply and divide run XLEN steps on serial_muldiv and finish with
// latency XLEN+2.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/in_0/in_1/operation in; busy/done/out/zero out
// OPW must be at least 5.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  state_t            state;
  logic [OPC_W-1:0]  opc, op_q;
  logic              neg_q, busy_q, done_q, zero_q;
  logic [XLEN-1:0]   out_q;

  logic [XLEN-1:0]   a, b, alu_res, fast_res, res1;
  logic [XLEN-1:0]   a_mag, b_mag, dv, div_res, mul_res, fin_res;
  logic [2*XLEN-1:0] acc, prod;
  logic              is_mul, is_div, div_rem, fast;
  logic              a_sgn, b_sgn, a_neg, b_neg, neg_d, cnt_done, load;

  assign a = bus.in_0;
  assign b = bus.in_1;
  // Codes with any bit set above bit 4 are unknown.
  // They map to 11111, which yields 0.
  assign opc = ((bus.operation >> OPC_W) == '0) ? bus.operation[OPC_W-1:0] : 5'b11111;

  assign is_mul  = (opc[4:2] == 3'b100);
  assign is_div  = (opc[4:2] == 3'b101);
  assign div_rem = opc[1];

  always_comb begin
    alu_res = '0;
    case (opc)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << b[SHW-1:0];
      OP_SRL:  alu_res = a >> b[SHW-1:0];
      OP_SUB:  alu_res = a - b;
      OP_SRA:  alu_res = XLEN'($signed(a) >>> b[SHW-1:0]);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      default: alu_res = '0;
    endcase
  end

  // Operand signedness.
  // MUL only uses the low half, which does not depend on sign, so it runs unsigned.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    if (is_mul) begin
      a_sgn = (opc[1:0] == 2'b01) || (opc[1:0] == 2'b10);
      b_sgn = (opc[1:0] == 2'b01);
    end else if (is_div) begin
      a_sgn = ~opc[0];
      b_sgn = ~opc[0];
    end
  end

  assign a_neg = a_sgn & a[XLEN-1];
  assign b_neg = b_sgn & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  // The remainder takes the sign of A.
  // The quotient and product take sign(A) xor sign(B).
  assign neg_d = (is_div && div_rem) ? a_neg : (a_neg ^ b_neg);

  // Divide by zero and signed overflow bypass the engine.
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (b == '0) begin
      fast     = 1'b1;
      fast_res = div_rem ? a : '1;
    end else if (!opc[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
      fast     = 1'b1;
      fast_res = div_rem ? '0 : a;
    end
  end

  assign res1 = is_div ? fast_res : alu_res;
  assign load = (state == S_IDLE) && bus.start && (is_mul || (is_div && !fast));

  serial_muldiv #(.XLEN(XLEN)) u_md (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .mode     (is_div),
    .iterate  (state == S_MUL || state == S_DIV),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .cnt_done (cnt_done),
    .acc      (acc)
  );

  // Sign fix-up and half selection, evaluated in the FIN state.
  assign prod    = neg_q ? -acc : acc;
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign dv      = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign div_res = neg_q ? -dv : dv;
  assign fin_res = op_q[2] ? div_res : mul_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      neg_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          if (load) begin
            state  <= is_mul ? S_MUL : S_DIV;
            op_q   <= opc;
            neg_q  <= neg_d;
            busy_q <= 1'b1;
          end else begin
            out_q  <= res1;
            zero_q <= (res1 == '0);
            done_q <= 1'b1;
          end
        end
        S_MUL, S_DIV: if (cnt_done) state <= S_FIN;
        S_FIN: begin
          out_q  <= fin_res;
          zero_q <= (fin_res == '0);
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.zero = zero_q;
endmodule
